// File: rtl/mux_key_table_pkg.sv
// Shared helpers for the programmable key->data lookup table.
package mux_key_pkg;

  // Index width for an n-entry table; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Field widths used when the table is built with its default geometry.
  localparam int DEF_KEY_LEN  = 2;
  localparam int DEF_DATA_LEN = 2;
  localparam int DEF_NR_KEY   = 4;
  localparam int DEF_IDX_W    = idx_w(DEF_NR_KEY);

  typedef struct packed {
    logic                    valid;
    logic [DEF_KEY_LEN-1:0]  key;
    logic [DEF_DATA_LEN-1:0] data;
  } entry_t;

  typedef struct packed {
    logic [DEF_DATA_LEN-1:0] data;
    logic                    hit;
    logic [DEF_IDX_W-1:0]    idx;
  } rsp_t;

endpackage

// File: rtl/mux_key_table_if.sv
// Write port, lookup request/response handshake and statistics of the key table.
// valid/ready: a beat transfers on a rising edge where valid && ready; the sender
// holds its payload stable while valid && !ready.
interface mux_key_table_if #(
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  parameter int IDX_W    = 2,
  parameter int CNT_W    = 16
);
  logic                wr_en;
  logic [IDX_W-1:0]    wr_idx;
  logic [KEY_LEN-1:0]  wr_key;
  logic [DATA_LEN-1:0] wr_data;
  logic                wr_set;
  logic                clr;
  logic                req_valid;
  logic                req_ready;
  logic [KEY_LEN-1:0]  req_key;
  logic [DATA_LEN-1:0] default_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_LEN-1:0] rsp_data;
  logic                rsp_hit;
  logic [IDX_W-1:0]    rsp_idx;
  logic [CNT_W-1:0]    stat_hits;
  logic [CNT_W-1:0]    stat_misses;

  modport master (
    output wr_en, wr_idx, wr_key, wr_data, wr_set, clr,
    output req_valid, req_key, default_out, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx, stat_hits, stat_misses
  );

  modport slave (
    input  wr_en, wr_idx, wr_key, wr_data, wr_set, clr,
    input  req_valid, req_key, default_out, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx, stat_hits, stat_misses
  );
endinterface

// File: rtl/mux_key_table_match.sv
// Combinational match of one key against all entries; the lowest matching index wins.
module mux_key_table_match
  import mux_key_pkg::*;
#(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  localparam int IDX_W   = idx_w(NR_KEY),
  localparam int ENT_W   = 1 + KEY_LEN + DATA_LEN
) (
  input  logic [NR_KEY-1:0][ENT_W-1:0] entries_i,
  input  logic [KEY_LEN-1:0]           key_i,
  output logic                         hit_o,
  output logic [IDX_W-1:0]             idx_o,
  output logic [DATA_LEN-1:0]          data_o
);
  typedef struct packed {
    logic                valid;
    logic [KEY_LEN-1:0]  key;
    logic [DATA_LEN-1:0] data;
  } ent_t;

  ent_t [NR_KEY-1:0] ents;
  assign ents = entries_i;

  // Scan from the top so the lowest matching index overwrites; data is selected, never ORed.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    data_o = '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (ents[i].valid && (ents[i].key == key_i)) begin
        hit_o  = 1'b1;
        idx_o  = IDX_W'(i);
        data_o = ents[i].data;
      end
    end
  end
endmodule

// File: rtl/mux_key_table.sv
// Run-time programmable key->data lookup table with a registered one-cycle response.
module mux_key_table
  import mux_key_pkg::*;
#(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 2,
  parameter int DATA_LEN    = 2,
  parameter int HAS_DEFAULT = 1,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = idx_w(NR_KEY),
  localparam int ENT_W      = 1 + KEY_LEN + DATA_LEN
) (
  input logic         clk,
  input logic         rst,
  mux_key_table_if.slave bus
);
  typedef struct packed {
    logic                valid;
    logic [KEY_LEN-1:0]  key;
    logic [DATA_LEN-1:0] data;
  } ent_t;

  typedef struct packed {
    logic [DATA_LEN-1:0] data;
    logic                hit;
    logic [IDX_W-1:0]    idx;
  } resp_t;

  ent_t [NR_KEY-1:0] ent_q, ent_d;
  resp_t             rsp_q, rsp_d;
  logic              rsp_valid_q;
  logic [CNT_W-1:0]  hits_q, misses_q;

  logic                m_hit;
  logic [IDX_W-1:0]    m_idx;
  logic [DATA_LEN-1:0] m_data;
  logic                accept;

  mux_key_table_match #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_match (
    .entries_i (ent_q),
    .key_i     (bus.req_key),
    .hit_o     (m_hit),
    .idx_o     (m_idx),
    .data_o    (m_data)
  );

  assign bus.req_ready   = !rsp_valid_q || bus.rsp_ready;
  assign accept          = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_q.data;
  assign bus.rsp_hit     = rsp_q.hit;
  assign bus.rsp_idx     = rsp_q.idx;
  assign bus.stat_hits   = hits_q;
  assign bus.stat_misses = misses_q;

  // Clear first, then the write; an out-of-range index matches no entry and is dropped.
  always_comb begin
    ent_d = ent_q;
    if (bus.clr) begin
      for (int i = 0; i < NR_KEY; i++) ent_d[i].valid = 1'b0;
    end
    for (int i = 0; i < NR_KEY; i++) begin
      if (bus.wr_en && (bus.wr_idx == IDX_W'(i))) begin
        ent_d[i].valid = bus.wr_set;
        ent_d[i].key   = bus.wr_key;
        ent_d[i].data  = bus.wr_data;
      end
    end
  end

  always_comb begin
    rsp_d.hit  = m_hit;
    rsp_d.idx  = m_hit ? m_idx : '0;
    rsp_d.data = m_hit ? m_data : ((HAS_DEFAULT != 0) ? bus.default_out : '0);
  end

  // The lookup reads ent_q, so same-cycle writes only become visible next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      hits_q      <= '0;
      misses_q    <= '0;
    end else begin
      ent_q <= ent_d;
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_q       <= rsp_d;
        if (m_hit) begin
          if (hits_q != '1) hits_q <= hits_q + 1'b1;
        end else begin
          if (misses_q != '1) misses_q <= misses_q + 1'b1;
        end
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mux_key_table.sv
// Directed bench for mux_key_table: table model with response queue plus literal checks.
module tb_mux_key_table;
  localparam int NR_KEY = 4;
  localparam int K      = 2;
  localparam int D      = 2;
  localparam int IW     = 2;
  localparam int W      = D + 1 + IW;

  logic clk;
  logic rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  mux_key_table_if #(.KEY_LEN(K), .DATA_LEN(D), .IDX_W(IW), .CNT_W(16)) bus ();
  mux_key_table_if #(.KEY_LEN(K), .DATA_LEN(D), .IDX_W(IW), .CNT_W(2))  sbus ();

  mux_key_table #(.NR_KEY(NR_KEY), .KEY_LEN(K), .DATA_LEN(D), .HAS_DEFAULT(1), .CNT_W(16))
    dut (.clk(clk), .rst(rst), .bus(bus));
  mux_key_table #(.NR_KEY(NR_KEY), .KEY_LEN(K), .DATA_LEN(D), .HAS_DEFAULT(1), .CNT_W(2))
    dut_sat (.clk(clk), .rst(rst), .bus(sbus));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (act=timeout req=finish)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic         m_valid [NR_KEY];
  logic [K-1:0] m_key   [NR_KEY];
  logic [D-1:0] m_data  [NR_KEY];
  logic [W-1:0] exp_q[$];
  int           m_hits, m_misses;
  logic         m_acc;

  function automatic logic [W-1:0] model_lookup(input logic [K-1:0] k, input logic [D-1:0] dflt);
    for (int i = 0; i < NR_KEY; i++)
      if (m_valid[i] && m_key[i] == k) return {m_data[i], 1'b1, IW'(i)};
    return {dflt, 1'b0, IW'(0)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_KEY; i++) begin
        m_valid[i] = 1'b0; m_key[i] = '0; m_data[i] = '0;
      end
      exp_q.delete();
      m_hits = 0; m_misses = 0;
    end else begin
      m_acc = bus.req_valid && (exp_q.size() == 0 || bus.rsp_ready);
      if (exp_q.size() != 0 && bus.rsp_ready) void'(exp_q.pop_front());
      if (m_acc) begin
        exp_q.push_back(model_lookup(bus.req_key, bus.default_out));
        if (exp_q[exp_q.size()-1][IW]) m_hits++; else m_misses++;
      end
      if (bus.clr) for (int i = 0; i < NR_KEY; i++) m_valid[i] = 1'b0;
      if (bus.wr_en && int'(bus.wr_idx) < NR_KEY) begin
        m_valid[bus.wr_idx] = bus.wr_set;
        m_key[bus.wr_idx]   = bus.wr_key;
        m_data[bus.wr_idx]  = bus.wr_data;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("req_ready", 32'(bus.req_ready), 32'(exp_q.size() == 0 || bus.rsp_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk("rsp_payload", 32'({bus.rsp_data, bus.rsp_hit, bus.rsp_idx}), 32'(exp_q[0]));
      chk("stat_hits", 32'(bus.stat_hits), 32'(m_hits));
      chk("stat_misses", 32'(bus.stat_misses), 32'(m_misses));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_e(input logic [IW-1:0] idx, input logic [K-1:0] k,
                         input logic [D-1:0] d, input logic set, input logic c);
    bus.wr_en = 1'b1; bus.wr_idx = idx; bus.wr_key = k; bus.wr_data = d;
    bus.wr_set = set; bus.clr = c;
    tick();
    bus.wr_en = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic lookup(input logic [K-1:0] k, input logic [D-1:0] dflt);
    bus.req_valid = 1'b1; bus.req_key = k; bus.default_out = dflt;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_rsp(input string name, input logic hit, input logic [IW-1:0] idx,
                         input logic [D-1:0] d);
    chk({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({name, "_hit"},   32'(bus.rsp_hit),   32'(hit));
    chk({name, "_idx"},   32'(bus.rsp_idx),   32'(idx));
    chk({name, "_data"},  32'(bus.rsp_data),  32'(d));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    {bus.wr_en, bus.wr_idx, bus.wr_key, bus.wr_data, bus.wr_set, bus.clr} = '0;
    {bus.req_valid, bus.req_key, bus.default_out} = '0;
    bus.rsp_ready = 1'b1;
    {sbus.wr_en, sbus.wr_idx, sbus.wr_key, sbus.wr_data, sbus.wr_set, sbus.clr} = '0;
    {sbus.req_valid, sbus.req_key, sbus.default_out} = '0;
    sbus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_bits",  32'({bus.rsp_data, bus.rsp_hit, bus.rsp_idx}), 32'd0);
    chk("reset_stats",     32'({bus.stat_hits, bus.stat_misses}), 32'd0);
    @(posedge clk); #1;

    // miss with default on empty table
    lookup(2'b10, 2'b11);
    chk_rsp("t1", 1'b0, 2'd0, 2'b11);
    chk("t1_misses", 32'(bus.stat_misses), 32'd1);
    tick();
    chk("t1_drain", 32'(bus.rsp_valid), 32'd0);

    // single programmed entry
    write_e(2'd2, 2'b01, 2'b10, 1'b1, 1'b0);
    lookup(2'b01, 2'b00);
    chk_rsp("t2", 1'b1, 2'd2, 2'b10);
    chk("t2_hits", 32'(bus.stat_hits), 32'd1);

    // duplicate keys: lowest index, no OR of data
    write_e(2'd1, 2'b11, 2'b01, 1'b1, 1'b0);
    write_e(2'd3, 2'b11, 2'b10, 1'b1, 1'b0);
    lookup(2'b11, 2'b00);
    chk_rsp("t3", 1'b1, 2'd1, 2'b01);
    tick();

    // back-pressure
    bus.rsp_ready = 1'b0;
    lookup(2'b01, 2'b00);
    bus.req_valid = 1'b1; bus.req_key = 2'b00; bus.default_out = 2'b01;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t4_stall_ready", 32'(bus.req_ready), 32'd0);
      chk_rsp("t4_stall", 1'b1, 2'd2, 2'b10);
      chk("t4_stall_stats", 32'({bus.stat_hits, bus.stat_misses}), {16'd3, 16'd1});
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk_rsp("t4_after", 1'b0, 2'd0, 2'b01);
    chk("t4_misses", 32'(bus.stat_misses), 32'd2);
    tick();
    chk("t4_drain", 32'(bus.rsp_valid), 32'd0);

    // read-before-write on the same cycle
    bus.req_valid = 1'b1; bus.req_key = 2'b01; bus.default_out = 2'b00;
    write_e(2'd2, 2'b01, 2'b10, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    chk_rsp("t5_rbw", 1'b1, 2'd2, 2'b10);
    lookup(2'b01, 2'b00);
    chk_rsp("t5_inval", 1'b0, 2'd0, 2'b00);
    write_e(2'd0, 2'b00, 2'b11, 1'b1, 1'b1);
    lookup(2'b00, 2'b01);
    chk_rsp("t5_clr_wr", 1'b1, 2'd0, 2'b11);
    lookup(2'b11, 2'b10);
    chk_rsp("t5_clr_gone", 1'b0, 2'd0, 2'b10);

    // back-to-back lookups, one per cycle
    bus.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.req_key = K'(k); bus.default_out = D'(3 - k);
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    chk("b2b_hits",   32'(bus.stat_hits),   32'd6);
    chk("b2b_misses", 32'(bus.stat_misses), 32'd7);

    // saturating counters on the CNT_W=2 instance
    sbus.wr_en = 1'b1; sbus.wr_idx = 2'd0; sbus.wr_key = 2'b00; sbus.wr_data = 2'b01;
    sbus.wr_set = 1'b1;
    tick();
    sbus.wr_en = 1'b0;
    sbus.req_valid = 1'b1; sbus.req_key = 2'b00;
    repeat (2) tick();
    chk("sat_two", 32'(sbus.stat_hits), 32'd2);
    repeat (3) tick();
    sbus.req_valid = 1'b0;
    chk("sat_hits", 32'(sbus.stat_hits), 32'd3);
    chk("sat_misses", 32'(sbus.stat_misses), 32'd0);

    // asynchronous reset drops a pending response
    lookup(2'b00, 2'b00);
    chk("rst_pre_valid", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_async_bits", 32'({bus.rsp_data, bus.rsp_hit, bus.rsp_idx}), 32'd0);
    chk("rst_async_stats", 32'({bus.stat_hits, bus.stat_misses}), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    lookup(2'b00, 2'b10);
    chk_rsp("rst_cleared", 1'b0, 2'd0, 2'b10);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
